// File: rtl/tug_field.sv
// Tug-of-war playfield: moves a single lit LED toward the pressing player and
// latches a winner when the light leaves either end. Optional macro: SCORE_TALLY_EN.
module tug_field #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_p,
  input  logic             right_p,
  output logic [WIDTH-1:0] leds,
  output logic [1:0]       winner,
  output logic             game_over
`ifdef SCORE_TALLY_EN
  ,
  output logic [2:0]       left_score,
  output logic [2:0]       right_score
`endif
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] CENTER  = PW'((WIDTH - 1) / 2);
  localparam logic [PW-1:0] MAX_POS = PW'(WIDTH - 1);

  localparam logic [1:0] PLAY = 2'd0;
  localparam logic [1:0] LWIN = 2'd1;
  localparam logic [1:0] RWIN = 2'd2;

  logic [1:0]       state, state_d;
  logic [PW-1:0]    pos, pos_d;
  logic [WIDTH-1:0] leds_d;
  logic [1:0]       winner_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case/if tree leaves it unassigned (which would infer a latch).
    state_d = state;
    pos_d   = pos;
    case (state)
      PLAY: begin
        // End-of-field checks come before the step, so pos can never wrap.
        if (left_p && !right_p) begin
          if (pos == MAX_POS) state_d = LWIN;
          else                pos_d   = pos + PW'(1);
        end else if (right_p && !left_p) begin
          if (pos == '0) state_d = RWIN;
          else           pos_d   = pos - PW'(1);
        end
      end
      LWIN, RWIN: begin
`ifdef SCORE_TALLY_EN
        if (left_p || right_p) begin
          state_d = PLAY;
          pos_d   = CENTER;
        end
`endif
      end
      default: begin
        state_d = PLAY;
        pos_d   = CENTER;
      end
    endcase
  end

  always_comb begin
    leds_d   = '0;
    winner_d = 2'b00;
    case (state_d)
      PLAY:    leds_d[pos_d] = 1'b1;
      LWIN:    winner_d = 2'b01;
      RWIN:    winner_d = 2'b10;
      default: winner_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from the values present before the edge.
    if (reset) begin
      state     <= PLAY;
      pos       <= CENTER;
      leds      <= '0;
      leds[CENTER] <= 1'b1;
      winner    <= 2'b00;
      game_over <= 1'b0;
    end else begin
      state     <= state_d;
      pos       <= pos_d;
      leds      <= leds_d;
      winner    <= winner_d;
      game_over <= (state_d != PLAY);
    end
  end

`ifdef SCORE_TALLY_EN
  // Scores count win entries only and saturate at 7; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      left_score  <= 3'd0;
      right_score <= 3'd0;
    end else if (state == PLAY) begin
      if (state_d == LWIN && left_score != 3'd7)  left_score  <= left_score + 3'd1;
      if (state_d == RWIN && right_score != 3'd7) right_score <= right_score + 3'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tug_field.sv
// Scoreboard bench for tug_field: driver pushes model predictions, a monitor
// pops and compares one prediction after every clock edge.
module tb_tug_field;

  localparam int WIDTH  = 9;
  localparam int CENTER = (WIDTH - 1) / 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             left_p = 1'b0;
  logic             right_p = 1'b0;
  logic [WIDTH-1:0] leds;
  logic [1:0]       winner;
  logic             game_over;
`ifdef SCORE_TALLY_EN
  logic [2:0]       left_score, right_score;
`endif

  tug_field #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .left_p(left_p), .right_p(right_p),
    .leds(leds), .winner(winner), .game_over(game_over)
`ifdef SCORE_TALLY_EN
    , .left_score(left_score), .right_score(right_score)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] leds;
    logic [1:0]       winner;
    logic             game_over;
    logic [2:0]       ls;
    logic [2:0]       rs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: signed position, winner code 0 none / 1 left / 2 right.
  int m_pos = CENTER;
  int m_win = 0;
  int m_ls  = 0;
  int m_rs  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic l, input logic r, input logic rs);
    exp_t e;
    logic [WIDTH-1:0] one;
    int np;
    @(negedge clk);
    left_p  = l;
    right_p = r;
    reset   = rs;
    if (rs) begin
      m_pos = CENTER; m_win = 0; m_ls = 0; m_rs = 0;
    end else if (m_win == 0) begin
      np = m_pos + int'(l) - int'(r);
      if (np >= WIDTH) begin
        m_win = 1;
        if (m_ls < 7) m_ls++;
      end else if (np < 0) begin
        m_win = 2;
        if (m_rs < 7) m_rs++;
      end else begin
        m_pos = np;
      end
    end else begin
`ifdef SCORE_TALLY_EN
      if (l || r) begin
        m_win = 0;
        m_pos = CENTER;
      end
`endif
    end
    one         = 1;
    e.leds      = (m_win != 0) ? '0 : (one << m_pos);
    e.winner    = 2'(m_win);
    e.game_over = (m_win != 0);
    e.ls        = 3'(m_ls);
    e.rs        = 3'(m_rs);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so one prediction is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("leds", 32'(leds), 32'(e.leds));
        check("winner", 32'(winner), 32'(e.winner));
        check("game_over", 32'(game_over), 32'(e.game_over));
`ifdef SCORE_TALLY_EN
        check("left_score", 32'(left_score), 32'(e.ls));
        check("right_score", 32'(right_score), 32'(e.rs));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, bias;
    step(0, 0, 1);                                  // reset -> center
    repeat (4) step(1, 0, 0);                       // to leftmost
    step(1, 0, 0);                                  // left wins
    repeat (3) step(1, 0, 0);                       // terminal or exit with tally
    step(0, 0, 1);
    repeat (3) step(1, 1, 0);                       // cancelled presses
    step(0, 1, 0);
    step(0, 0, 1);
    repeat (5) step(0, 1, 0);                       // right wins
    repeat (3) step(1, 0, 0);
    step(0, 0, 1);
    repeat (2) step(1, 0, 0);
    step(0, 1, 1);                                  // reset beats pulse
    repeat (8) begin                                // saturation of left score
      repeat (5) step(1, 0, 0);
      step(0, 1, 0);
    end
    step(0, 0, 1);

    bias = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 25 == 0) bias = $urandom_range(0, 2);
      p = $urandom_range(0, 9);
      case (bias)
        0:       step(p < 6, p >= 5, $urandom_range(0, 79) == 0);
        1:       step(p >= 5, p < 6 && p >= 4, $urandom_range(0, 79) == 0);
        default: step(p[0], p[1], $urandom_range(0, 79) == 0);
      endcase
    end

    @(negedge clk);
    left_p = 1'b0; right_p = 1'b0; reset = 1'b0;
    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tug_field.md
# tug_field

Playfield stage of the two-player tug-of-war game. Consumes the one-cycle press pulses produced by each player's button-conditioning stage, moves a single lit position along a row of LEDs toward the player who pressed, and declares a winner when the light is pulled off either end. Outputs drive LEDR directly, plus a winner code for the HEX display stage.

## Interface

Parameters:
- WIDTH, 9: number of field LEDs. Must be odd and ≥ 3.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high. Dominates all other inputs.
- left_p  in  1  one-cycle press pulse from the left player's conditioning stage.
- right_p  in  1  one-cycle press pulse from the right player's conditioning stage.
- leds  out  WIDTH  one-hot field. leds[WIDTH-1] is the leftmost LED and leds[0] the rightmost. All zeros after a win.
- winner  out  2  2'b00 none, 2'b01 left, 2'b10 right. 2'b11 never driven.
- game_over  out  1  high while in a win state.
- left_score  out  3  left win count. Present only with SCORE_TALLY_EN.
- right_score  out  3  right win count. Present only with SCORE_TALLY_EN.

## Operation

- Internal position `pos` ranges 0..WIDTH-1. CENTER = (WIDTH-1)/2. In PLAY, leds = 1 << pos.
- The state machine has three states: PLAY, LWIN, RWIN.
- PLAY, left_p=1 and right_p=0:
  - if pos == WIDTH-1, go to LWIN;
  - otherwise pos <= pos+1.
- PLAY, right_p=1 and left_p=0:
  - if pos == 0, go to RWIN;
  - otherwise pos <= pos-1.
- PLAY, both pulses high or both low: hold. Simultaneous presses cancel.
- LWIN: leds = 0, winner = 01, game_over = 1.
- RWIN: leds = 0, winner = 10, game_over = 1.
- Win-state exit is set by configuration; see Configuration.
- Inputs are treated as pulses. A level held high for k cycles counts as k presses. Rejecting held levels is the responsibility of the upstream stage.
- Arithmetic: pos is $clog2(WIDTH) bits. It never wraps, because the end-of-field checks take priority over the increment/decrement.

## Timing

- All outputs are registered. A pulse sampled at edge N is reflected on leds/winner/game_over immediately after edge N, i.e. 1-cycle latency.
- Reset values:
  - pos = CENTER, so leds = one-hot at CENTER;
  - winner = 00, game_over = 0, state = PLAY;
  - scores = 0.
- Reset asserted mid-game or in a win state: at the next edge, return to the reset values regardless of left_p/right_p.
- Reset and a pulse in the same cycle: reset wins and the pulse is discarded.
- Back-to-back pulses on consecutive cycles each move the light one position.

## Configuration

- Macro: SCORE_TALLY_EN.
- Undefined:
  - LWIN/RWIN are terminal until reset; all pulses are ignored;
  - left_score/right_score ports do not exist.
- Defined:
  - entering LWIN increments left_score and entering RWIN increments right_score, on the same edge as the state change;
  - scores saturate at 7;
  - in a win state, any pulse (either player) returns to PLAY with pos = CENTER on the next edge;
  - scores clear only on reset.

## Test plan

All scenarios use WIDTH=9.

- Reset for 1 cycle -> leds = 9'b000010000, winner = 00, game_over = 0.
- 4 left_p pulses -> leds = 9'b100000000. Fifth pulse -> leds = 0, winner = 01, game_over = 1 one cycle later.
- left_p and right_p high together for 3 cycles from center -> leds stays 9'b000010000. Then a single right_p -> 9'b000001000.
- Macro off, in RWIN: 3 left_p pulses -> leds remains 0 and winner remains 10. Reset -> center.
- Two left_p pulses (leds = 9'b001000000), then reset concurrent with right_p -> next cycle leds = 9'b000010000.
- SCORE_TALLY_EN:
  - left win -> left_score = 1; next right_p -> leds = 9'b000010000, game_over = 0;
  - repeat 8 left wins -> left_score saturates at 7;
  - reset -> left_score = 0.
